trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, default 32, PC width.
- INSTR_W, default 32, instruction width.
- DEPTH, default 16, entry count; power of 2, at least 2.
- TS_W, default 16, timestamp width.
- WRAP_MODE, default 0; 0 = stop when full, 1 = circular overwrite.
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- arm  in  1  start or restart capture.
- stop  in  1  end capture.
- trig_en  in  1  enable PC trigger.
- trig_pc  in  ADDR_W  trigger address.
- fetch_valid  in  1  fetch strobe (processor IRWrite).
- fetch_pc  in  ADDR_W  PC of the fetched instruction.
- fetch_instr  in  INSTR_W  fetched instruction.
- rd_valid  out  1  entry available.
- rd_ready  in  1  consumer accepts entry.
- rd_pc  out  ADDR_W  oldest entry PC.
- rd_instr  out  INSTR_W  oldest entry instruction.
- rd_ts  out  TS_W  oldest entry timestamp.
- count  out  clog2(DEPTH)+1  stored entries.
- state  out  2  FSM state.
- overflow  out  1  sticky flag: entry overwritten.

Function
REQ-003 FSM states SHALL be IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-004 arm SHALL take priority in every state:
- Next cycle: state=ARMED, count=0, pointers=0, overflow=0, timestamp=0.
- A fetch_valid in the same cycle as arm SHALL be discarded.
REQ-005 Timestamp counter SHALL increment by 1 every cycle in ARMED or CAPTURE and wrap modulo 2^TS_W.
- It SHALL hold its value in IDLE and DONE.
- The stored ts SHALL be the counter value in the capture cycle.
REQ-006 ARMED with trig_en=0 SHALL go to CAPTURE next cycle without capturing an entry.
REQ-007 ARMED with trig_en=1 SHALL capture a fetch only when fetch_valid=1 and fetch_pc==trig_pc.
- That fetch SHALL be written as the first entry and state SHALL go to CAPTURE.
- Non-matching fetches SHALL be ignored.
REQ-008 In CAPTURE, each cycle with fetch_valid=1 SHALL write {fetch_pc, fetch_instr, ts} at the write pointer.
- count SHALL reflect the write on the following cycle (1-cycle latency).
REQ-009 WRAP_MODE=0: the write that makes count=DEPTH SHALL move state to DONE next cycle; no further writes SHALL occur.
REQ-010 WRAP_MODE=1 with count=DEPTH: a write SHALL overwrite the oldest entry.
- The read pointer SHALL advance, count SHALL stay DEPTH, and overflow SHALL be set.
REQ-011 stop in CAPTURE or ARMED SHALL move state to DONE next cycle.
- A fetch_valid coinciding with stop in CAPTURE SHALL still be captured.
REQ-012 stop SHALL be ignored in IDLE and DONE.
REQ-013 rd_valid SHALL equal (state==DONE && count!=0).
- When rd_valid=0, rd_pc, rd_instr and rd_ts SHALL be 0.
- When rd_valid=1, they SHALL show the oldest entry combinationally.
REQ-014 rd_valid && rd_ready SHALL pop the oldest entry: read pointer +1 modulo DEPTH, count -1 next cycle.
- rd_ready SHALL be ignored when rd_valid=0.
REQ-015 Pointers SHALL wrap modulo DEPTH.
- Entries SHALL pop in capture order, oldest first.
- DONE SHALL persist until arm or reset.

Reset
REQ-016 On reset: state=IDLE, count=0, pointers=0, timestamp=0, overflow=0, rd_valid=0, and all rd_* outputs 0.
REQ-017 Reset during ARMED or CAPTURE SHALL discard all entries.
- Stored array contents need not be cleared.
- reset SHALL override arm and stop.

Structure
REQ-018 A shared package trace_pkg SHALL hold:
- the state encoding constants;
- the entry-width helper (ADDR_W+INSTR_W+TS_W);
- the WRAP_MODE constants STOP_FULL=0 and CIRCULAR=1.
REQ-019 Storage SHALL be one sub-module, trace_ram.
- DEPTH x entry array, synchronous write, asynchronous read.
- The FSM, pointers and counters SHALL remain in trace_buffer.

Verification
REQ-020 Untriggered capture, stop-when-full: DEPTH=4, WRAP_MODE=0, trig_en=0, arm, then 6 fetches at PC 0x00,0x04,...,0x14.
- Required: state DONE after the 4th write, count=4, overflow=0.
- Pops SHALL return PCs 0x00,0x04,0x08,0x0C with ts strictly increasing.
REQ-021 Triggered capture: trig_en=1, trig_pc=0x10, fetches at 0x08,0x0C,0x10,0x14, then stop.
- Required: count=2, entries 0x10 then 0x14.
REQ-022 Circular overwrite: DEPTH=4, WRAP_MODE=1, 6 fetches at PC 0x00..0x14, then stop.
- Required: overflow=1, count=4, pops return 0x08,0x0C,0x10,0x14.
REQ-023 Simultaneous stop and fetch: stop and fetch_valid (PC 0x20) in the same cycle.
- Required: 0x20 stored, state DONE next cycle.
- Readout with rd_ready held low SHALL keep rd_valid=1 and count unchanged.
REQ-024 Restart and reset mid-operation:
- arm in DONE with 3 entries SHALL give count=0, state ARMED, rd_valid=0 next cycle.
- reset during CAPTURE SHALL give state IDLE and count=0 next cycle.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the instruction trace buffer:
// FSM state encoding, wrap-mode selectors and the entry-width helper.
package trace_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ARMED   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    localparam int STOP_FULL = 0;
    localparam int CIRCULAR  = 1;

    function automatic int entry_width(input int addr_w, input int instr_w, input int ts_w);
        return addr_w + instr_w + ts_w;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Entry storage for the trace buffer: synchronous write, asynchronous read.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int WIDTH = 80
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_buffer.sv
// Instruction trace buffer: captures {pc, instr, timestamp} for each fetch
// between arm/trigger and stop, then drains oldest-first through a valid/ready port.
module trace_buffer
    import trace_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int INSTR_W   = 32,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 16,
    parameter int WRAP_MODE = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   stop,
    input  logic                   trig_en,
    input  logic [ADDR_W-1:0]      trig_pc,
    input  logic                   fetch_valid,
    input  logic [ADDR_W-1:0]      fetch_pc,
    input  logic [INSTR_W-1:0]     fetch_instr,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [ADDR_W-1:0]      rd_pc,
    output logic [INSTR_W-1:0]     rd_instr,
    output logic [TS_W-1:0]        rd_ts,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             state,
    output logic                   overflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_width(ADDR_W, INSTR_W, TS_W);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              overflow_q, overflow_d;

    logic               wr_en;
    logic [ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0] rd_entry;
    logic               rd_valid_int;

    assign rd_valid_int = (state_q == ST_DONE) && (count_q != '0);
    assign wr_data      = {fetch_pc, fetch_instr, ts_q};

    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        ts_d       = ts_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;

        if (arm) begin
            // Restart wins over everything, including a fetch in the same cycle.
            state_d    = ST_ARMED;
            wptr_d     = '0;
            rptr_d     = '0;
            count_d    = '0;
            ts_d       = '0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    ts_d = ts_q + TS_W'(1);
                    if (stop) begin
                        state_d = ST_DONE;
                    end else if (!trig_en) begin
                        state_d = ST_CAPTURE;
                    end else if (fetch_valid && (fetch_pc == trig_pc)) begin
                        wr_en   = 1'b1;
                        wptr_d  = wptr_q + PTR_W'(1);
                        count_d = count_q + CNT_W'(1);
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    ts_d = ts_q + TS_W'(1);
                    if (fetch_valid) begin
                        if (count_q == FULL_COUNT) begin
                            // Only reachable in circular mode: overwrite the oldest slot.
                            if (WRAP_MODE == CIRCULAR) begin
                                wr_en      = 1'b1;
                                wptr_d     = wptr_q + PTR_W'(1);
                                rptr_d     = rptr_q + PTR_W'(1);
                                overflow_d = 1'b1;
                            end
                        end else begin
                            wr_en   = 1'b1;
                            wptr_d  = wptr_q + PTR_W'(1);
                            count_d = count_q + CNT_W'(1);
                            if ((WRAP_MODE == STOP_FULL) && (count_q == FULL_COUNT - CNT_W'(1))) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                    if (stop) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (rd_valid_int && rd_ready) begin
                        rptr_d  = rptr_q + PTR_W'(1);
                        count_d = count_q - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wptr_q),
        .wdata (wr_data),
        .raddr (rptr_q),
        .rdata (rd_entry)
    );

    assign rd_valid = rd_valid_int;
    assign rd_pc    = rd_valid_int ? rd_entry[ENTRY_W-1 -: ADDR_W]  : '0;
    assign rd_instr = rd_valid_int ? rd_entry[TS_W +: INSTR_W]      : '0;
    assign rd_ts    = rd_valid_int ? rd_entry[TS_W-1:0]             : '0;
    assign count    = count_q;
    assign state    = state_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_trace_buffer.sv
// Bench for trace_buffer: two instances (stop-when-full and circular) share stimulus
// and are compared every cycle against a queue-based model, plus directed literal checks.
module tb_trace_buffer;

    localparam int AW = 16;
    localparam int IW = 16;
    localparam int DP = 4;
    localparam int TW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, arm, stop, trig_en, fetch_valid, rd_ready;
    logic [AW-1:0] trig_pc, fetch_pc;
    logic [IW-1:0] fetch_instr;

    logic          rv  [2];
    logic [AW-1:0] rpc [2];
    logic [IW-1:0] rin [2];
    logic [TW-1:0] rts [2];
    logic [2:0]    cnt [2];
    logic [1:0]    st  [2];
    logic          ovf [2];

    trace_buffer #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP), .TS_W(TW), .WRAP_MODE(0)) u_stop (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .rd_valid(rv[0]), .rd_ready(rd_ready), .rd_pc(rpc[0]), .rd_instr(rin[0]), .rd_ts(rts[0]),
        .count(cnt[0]), .state(st[0]), .overflow(ovf[0]));

    trace_buffer #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP), .TS_W(TW), .WRAP_MODE(1)) u_circ (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .trig_en(trig_en), .trig_pc(trig_pc),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
        .rd_valid(rv[1]), .rd_ready(rd_ready), .rd_pc(rpc[1]), .rd_instr(rin[1]), .rd_ts(rts[1]),
        .count(cnt[1]), .state(st[1]), .overflow(ovf[1]));

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
        logic [TW-1:0] ts;
    } ent_t;

    ent_t          mq [2][$];
    int            mstate [2];
    logic [TW-1:0] mts [2];
    bit            movf [2];
    bit            model_live = 1'b0;

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Model: instance 0 stops when full, instance 1 overwrites the oldest entry.
    task automatic model_step(input int m);
        ent_t e;
        e.pc    = fetch_pc;
        e.instr = fetch_instr;
        e.ts    = mts[m];
        if (reset) begin
            mstate[m] = 0; mq[m].delete(); mts[m] = '0; movf[m] = 1'b0;
        end else if (arm) begin
            mstate[m] = 1; mq[m].delete(); mts[m] = '0; movf[m] = 1'b0;
        end else begin
            case (mstate[m])
                1: begin
                    mts[m] = mts[m] + 8'd1;
                    if (stop) mstate[m] = 3;
                    else if (!trig_en) mstate[m] = 2;
                    else if (fetch_valid && fetch_pc == trig_pc) begin
                        mq[m].push_back(e);
                        mstate[m] = 2;
                    end
                end
                2: begin
                    mts[m] = mts[m] + 8'd1;
                    if (fetch_valid) begin
                        if (mq[m].size() == DP) begin
                            if (m == 1) begin
                                void'(mq[m].pop_front());
                                mq[m].push_back(e);
                                movf[m] = 1'b1;
                            end
                        end else begin
                            mq[m].push_back(e);
                            if (m == 0 && mq[m].size() == DP) mstate[m] = 3;
                        end
                    end
                    if (stop) mstate[m] = 3;
                end
                3: begin
                    if (mq[m].size() != 0 && rd_ready) void'(mq[m].pop_front());
                end
                default: begin
                end
            endcase
        end
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) model_step(m);
        model_live = 1'b1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            for (int m = 0; m < 2; m++) begin
                bit   ev;
                ent_t h;
                ev = (mstate[m] == 3) && (mq[m].size() != 0);
                h  = ev ? mq[m][0] : '0;
                checkOutput($sformatf("u%0d state", m),    32'(st[m]),  32'(mstate[m]));
                checkOutput($sformatf("u%0d count", m),    32'(cnt[m]), 32'(mq[m].size()));
                checkOutput($sformatf("u%0d overflow", m), 32'(ovf[m]), 32'(movf[m]));
                checkOutput($sformatf("u%0d rd_valid", m), 32'(rv[m]),  32'(ev));
                checkOutput($sformatf("u%0d rd_pc", m),    32'(rpc[m]), 32'(h.pc));
                checkOutput($sformatf("u%0d rd_instr", m), 32'(rin[m]), 32'(h.instr));
                checkOutput($sformatf("u%0d rd_ts", m),    32'(rts[m]), 32'(h.ts));
            end
        end
    end

    // Drive one cycle of inputs, let the edge consume them, return 1 time unit after it.
    task automatic applyStimulus(input logic a_reset, input logic a_arm, input logic a_stop,
                                 input logic a_fv, input logic [AW-1:0] a_pc, input logic a_rdr);
        reset       = a_reset;
        arm         = a_arm;
        stop        = a_stop;
        fetch_valid = a_fv;
        fetch_pc    = a_pc;
        fetch_instr = a_pc ^ 16'hBEEF;
        rd_ready    = a_rdr;
        @(posedge clk);
        #1;
    endtask

    task automatic doIdle();              applyStimulus(0, 0, 0, 0, '0, 0); endtask
    task automatic doArm();               applyStimulus(0, 1, 0, 0, '0, 0); endtask
    task automatic doStop();              applyStimulus(0, 0, 1, 0, '0, 0); endtask
    task automatic doPop();               applyStimulus(0, 0, 0, 0, '0, 1); endtask
    task automatic doFetch(input logic [AW-1:0] pc); applyStimulus(0, 0, 0, 1, pc, 0); endtask

    initial begin
        reset = 1'b1; arm = 1'b0; stop = 1'b0; trig_en = 1'b0; trig_pc = '0;
        fetch_valid = 1'b0; fetch_pc = '0; fetch_instr = '0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset state", 32'(st[0]), 32'd0);
        checkOutput("reset count", 32'(cnt[0]), 32'd0);
        checkOutput("reset rd_valid", 32'(rv[0]), 32'd0);
        checkOutput("reset rd_pc", 32'(rpc[0]), 32'd0);
        checkOutput("reset overflow", 32'(ovf[1]), 32'd0);

        // Untriggered capture of six fetches: stop-when-full vs circular.
        doArm();
        checkOutput("arm state", 32'(st[0]), 32'd1);
        doIdle();
        checkOutput("armed->capture", 32'(st[0]), 32'd2);
        for (int i = 0; i < 4; i++) doFetch(AW'(i * 4));
        checkOutput("full stop state", 32'(st[0]), 32'd3);
        checkOutput("full stop count", 32'(cnt[0]), 32'd4);
        checkOutput("full stop overflow", 32'(ovf[0]), 32'd0);
        doFetch(16'h0010);
        doFetch(16'h0014);
        checkOutput("stop mode count held", 32'(cnt[0]), 32'd4);
        checkOutput("circ count", 32'(cnt[1]), 32'd4);
        checkOutput("circ overflow", 32'(ovf[1]), 32'd1);
        doStop();
        checkOutput("circ stop state", 32'(st[1]), 32'd3);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stop pop pc", 32'(rpc[0]), 32'(i * 4));
            checkOutput("stop pop ts", 32'(rts[0]), 32'(i + 1));
            checkOutput("circ pop pc", 32'(rpc[1]), 32'(8 + i * 4));
            checkOutput("circ pop ts", 32'(rts[1]), 32'(i + 3));
            doPop();
        end
        checkOutput("drained rd_valid", 32'(rv[0]), 32'd0);
        checkOutput("drained count", 32'(cnt[1]), 32'd0);

        // PC trigger at 0x10.
        trig_en = 1'b1; trig_pc = 16'h0010;
        doArm();
        doFetch(16'h0008);
        doFetch(16'h000C);
        checkOutput("trig wait state", 32'(st[0]), 32'd1);
        doFetch(16'h0010);
        doFetch(16'h0014);
        doStop();
        checkOutput("trig count", 32'(cnt[0]), 32'd2);
        checkOutput("trig first pc", 32'(rpc[0]), 32'h10);
        checkOutput("trig first instr", 32'(rin[0]), 32'hBEFF);
        checkOutput("trig first ts", 32'(rts[0]), 32'd2);
        doPop();
        checkOutput("trig second pc", 32'(rpc[0]), 32'h14);
        doPop();
        trig_en = 1'b0;

        // Stop coinciding with a fetch; readout with rd_ready low.
        doArm();
        doIdle();
        applyStimulus(0, 0, 1, 1, 16'h0020, 0);
        checkOutput("stop+fetch state", 32'(st[0]), 32'd3);
        checkOutput("stop+fetch count", 32'(cnt[0]), 32'd1);
        checkOutput("stop+fetch pc", 32'(rpc[0]), 32'h20);
        repeat (3) begin
            doIdle();
            checkOutput("hold rd_valid", 32'(rv[0]), 32'd1);
            checkOutput("hold count", 32'(cnt[0]), 32'd1);
        end

        // Re-arm from DONE, then reset mid-capture.
        doArm();
        doIdle();
        doFetch(16'h0030); doFetch(16'h0034); doFetch(16'h0038);
        doStop();
        checkOutput("pre-rearm count", 32'(cnt[0]), 32'd3);
        doArm();
        checkOutput("rearm count", 32'(cnt[0]), 32'd0);
        checkOutput("rearm state", 32'(st[0]), 32'd1);
        checkOutput("rearm rd_valid", 32'(rv[0]), 32'd0);
        doIdle();
        doFetch(16'h0040); doFetch(16'h0044);
        applyStimulus(1, 1, 1, 1, 16'h0048, 0);
        checkOutput("mid reset state", 32'(st[0]), 32'd0);
        checkOutput("mid reset count", 32'(cnt[0]), 32'd0);

        // Randomized traffic, checked cycle by cycle against the model.
        trig_pc = 16'h0010;
        for (int c = 0; c < 800; c++) begin
            logic [AW-1:0] pc;
            if ($urandom_range(0, 49) == 0) trig_en = ~trig_en;
            pc = ($urandom_range(0, 3) == 0) ? 16'h0010 : AW'($urandom_range(0, 255) * 4);
            applyStimulus(($urandom_range(0, 199) == 0),
                          ($urandom_range(0, 24) == 0),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 9) < 6),
                          pc,
                          ($urandom_range(0, 1) == 1));
        end
        doIdle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
